lh_msg_framer: RTL and testbench



---
 rtl/lh_pkg.sv | 35 +++
 rtl/lh_byte_fifo.sv | 51 +++++
 rtl/lh_msg_framer.sv | 192 +++++++++++++++++++
 tb/tb_lh_msg_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lh_pkg.sv
// Shared types and constants for the light-hash message framer.
// Charset bounds are used only when LH_FRAMER_CHARSET_EN is defined.
package lh_pkg;

   localparam logic [7:0] LH_HEAD   = 8'hFF;
   localparam logic [7:0] LH_TAIL   = 8'h00;
   localparam logic [7:0] CS_LO_MIN = 8'h20;
   localparam logic [7:0] CS_LO_MAX = 8'h7E;
   localparam logic [7:0] CS_HI_MIN = 8'hA1;
   localparam logic [7:0] CS_HI_MAX = 8'hFE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEAD,
      ST_PAYLOAD,
      ST_GAP,
      ST_TAIL,
      ST_WAIT_DIG
   } framer_state_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   function automatic logic is_reserved(input logic [7:0] b);
      return (b == LH_HEAD) || (b == LH_TAIL);
   endfunction

   function automatic logic in_charset(input logic [7:0] b);
      return ((b >= CS_LO_MIN) && (b <= CS_LO_MAX)) ||
             ((b >= CS_HI_MIN) && (b <= CS_HI_MAX));
   endfunction

endpackage

// File: rtl/lh_byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered not-full ready flag.
module lh_byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter type entry_t = logic [8:0]
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t pop_data_c,
   output logic   empty_c,
   output logic   ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_nxt;
   logic [PW-1:0] rd_ptr_nxt;
   logic          do_push;
   logic          do_pop;

   assign empty_c    = (wr_ptr == rd_ptr);
   assign do_pop     = pop && !empty_c;
   assign do_push    = push && ready;
   assign wr_ptr_nxt = wr_ptr + PW'(do_push);
   assign rd_ptr_nxt = rd_ptr + PW'(do_pop);
   assign pop_data_c = mem[rd_ptr[AW-1:0]];

   // Ready reflects the post-update occupancy, so a pop never frees a slot in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ready  <= 1'b1;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         ready  <= ((wr_ptr_nxt ^ rd_ptr_nxt) != {1'b1, {AW{1'b0}}});
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/lh_msg_framer.sv
// Frames host messages as FF, payload, 00 and paces them to the hash core.
// Optional LH_FRAMER_CHARSET_EN adds a charset filter and the err_charset flag.
module lh_msg_framer
   import lh_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned BYTE_GAP = 34,
   parameter int unsigned MAX_LEN  = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [7:0]  message_byte,
   output logic        message_valid,
   input  logic        digest_ready,
   output logic        busy,
   output logic        err_overflow,
   output logic [15:0] frame_count
`ifdef LH_FRAMER_CHARSET_EN
   ,
   output logic        err_charset
`endif
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned GW = $clog2(BYTE_GAP);

   framer_state_t state, state_nxt;
   framer_state_t ret, ret_nxt;
   logic [LW-1:0] len, len_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic          discard, discard_nxt;
   logic [7:0]    byte_nxt;
   logic          valid_nxt;
   logic          ovf_nxt;
   logic [15:0]   fc_nxt;
   logic          pop_c;
   logic          drop_c;
   logic          push_c;
   logic          fifo_empty_c;
   fifo_entry_t   push_entry_c;
   fifo_entry_t   pop_entry_c;

   // Dropped bytes carrying last become a tail-valued marker so the frame still closes.
`ifdef LH_FRAMER_CHARSET_EN
   logic cs_drop_c;
   logic cs_nxt;
   assign cs_drop_c = !is_reserved(in_byte) && !in_charset(in_byte);
   assign drop_c    = is_reserved(in_byte) || cs_drop_c;
`else
   assign drop_c    = is_reserved(in_byte);
`endif
   assign push_c            = in_valid && in_ready && (!drop_c || in_last);
   assign push_entry_c.last = in_last;
   assign push_entry_c.data = drop_c ? LH_TAIL : in_byte;

   lh_byte_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fifo_entry_t)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_c),
      .push_data  (push_entry_c),
      .pop        (pop_c),
      .pop_data_c (pop_entry_c),
      .empty_c    (fifo_empty_c),
      .ready      (in_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         ret           <= ST_PAYLOAD;
         len           <= '0;
         gap_cnt       <= '0;
         discard       <= 1'b0;
         message_byte  <= LH_HEAD;
         message_valid <= 1'b0;
         busy          <= 1'b0;
         err_overflow  <= 1'b0;
         frame_count   <= '0;
      end else begin
         state         <= state_nxt;
         ret           <= ret_nxt;
         len           <= len_nxt;
         gap_cnt       <= gap_nxt;
         discard       <= discard_nxt;
         message_byte  <= byte_nxt;
         message_valid <= valid_nxt;
         busy          <= (state_nxt != ST_IDLE);
         err_overflow  <= ovf_nxt;
         frame_count   <= fc_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ret_nxt     = ret;
      len_nxt     = len;
      gap_nxt     = gap_cnt;
      discard_nxt = discard;
      byte_nxt    = message_byte;
      valid_nxt   = 1'b0;
      ovf_nxt     = err_overflow;
      fc_nxt      = frame_count;
      pop_c       = 1'b0;
`ifdef LH_FRAMER_CHARSET_EN
      cs_nxt      = err_charset;
`endif

      // Overflowed message: flush remaining entries through its last flag.
      if (discard && !fifo_empty_c) begin
         pop_c = 1'b1;
         if (pop_entry_c.last) discard_nxt = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            if (!fifo_empty_c && !discard) begin
               state_nxt = ST_HEAD;
               ovf_nxt   = 1'b0;
               len_nxt   = '0;
`ifdef LH_FRAMER_CHARSET_EN
               cs_nxt    = 1'b0;
`endif
            end
         end
         ST_HEAD: begin
            byte_nxt  = LH_HEAD;
            valid_nxt = 1'b1;
            ret_nxt   = ST_PAYLOAD;
            gap_nxt   = '0;
            state_nxt = ST_GAP;
         end
         ST_PAYLOAD: begin
            if (!fifo_empty_c) begin
               pop_c = 1'b1;
               if (pop_entry_c.last && (pop_entry_c.data == LH_TAIL)) begin
                  state_nxt = ST_TAIL;
               end else begin
                  byte_nxt  = pop_entry_c.data;
                  valid_nxt = 1'b1;
                  len_nxt   = len + LW'(1);
                  gap_nxt   = '0;
                  state_nxt = ST_GAP;
                  if (pop_entry_c.last) begin
                     ret_nxt = ST_TAIL;
                  end else if (len_nxt == LW'(MAX_LEN)) begin
                     ovf_nxt     = 1'b1;
                     discard_nxt = 1'b1;
                     ret_nxt     = ST_TAIL;
                  end else begin
                     ret_nxt = ST_PAYLOAD;
                  end
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == GW'(BYTE_GAP - 2)) state_nxt = ret;
            else gap_nxt = gap_cnt + GW'(1);
         end
         ST_TAIL: begin
            byte_nxt  = LH_TAIL;
            valid_nxt = 1'b1;
            state_nxt = ST_WAIT_DIG;
         end
         ST_WAIT_DIG: begin
            if (digest_ready) begin
               fc_nxt    = frame_count + 16'd1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

`ifdef LH_FRAMER_CHARSET_EN
      if (in_valid && in_ready && cs_drop_c) cs_nxt = 1'b1;
`endif
   end

`ifdef LH_FRAMER_CHARSET_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_charset <= 1'b0;
      else        err_charset <= cs_nxt;
   end
`endif

endmodule

// File: tb/tb_lh_msg_framer.sv
// Directed self-checking bench for lh_msg_framer (MAX_LEN reduced to 20).
module tb_lh_msg_framer;

   localparam int unsigned DEPTH    = 16;
   localparam int unsigned BYTE_GAP = 34;
   localparam int unsigned MAX_LEN  = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [7:0]  message_byte;
   logic        message_valid;
   logic        digest_ready;
   logic        busy;
   logic        err_overflow;
   logic [15:0] frame_count;
`ifdef LH_FRAMER_CHARSET_EN
   logic        err_charset;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int push_cyc = 0;
   logic [7:0] got [$];
   int         got_t [$];

   lh_msg_framer #(.DEPTH(DEPTH), .BYTE_GAP(BYTE_GAP), .MAX_LEN(MAX_LEN)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_byte       (in_byte),
      .in_valid      (in_valid),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .message_byte  (message_byte),
      .message_valid (message_valid),
      .digest_ready  (digest_ready),
      .busy          (busy),
      .err_overflow  (err_overflow),
      .frame_count   (frame_count)
`ifdef LH_FRAMER_CHARSET_EN
      ,
      .err_charset   (err_charset)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (message_valid) begin
         got.push_back(message_byte);
         got_t.push_back(cyc);
      end
   end

   // Hash-core model: acknowledge the digest 5 cycles after each tail byte.
   initial begin
      digest_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && message_valid && message_byte == 8'h00) begin
            repeat (5) @(negedge clk);
            digest_ready = 1'b1;
            @(negedge clk);
            digest_ready = 1'b0;
         end
      end
   end

   task automatic push_byte(input logic [7:0] b, input logic l);
      int n = 0;
      in_byte  = b;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL push_timeout byte=%02h in_ready=%b required=1", b, in_ready);
      end else begin
         push_cyc = cyc + 1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      int k = 0;
      while (got.size() < n && k < 5000) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      checks++;
      if (got.size() < n) begin
         failures++;
         $display("FAIL wait_bytes got=%0d required=%0d", got.size(), n);
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL wait_idle busy=%b required=0", busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (message_byte !== 8'hFF || message_valid !== 1'b0 || busy !== 1'b0 ||
          err_overflow !== 1'b0 || frame_count !== 16'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_values byte=%02h valid=%b busy=%b ovf=%b fc=%0d rdy=%b required FF/0/0/0/0/1",
                  message_byte, message_valid, busy, err_overflow, frame_count, in_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] exp_q [$];
      exp_q = '{8'hFF, 8'h61, 8'h62, 8'h63, 8'h00};
      got.delete(); got_t.delete();
      push_byte(8'h61, 1'b0);
      begin int first_push; first_push = push_cyc;
         push_byte(8'h62, 1'b0);
         push_byte(8'h63, 1'b1);
         wait_bytes(5);
         checks++;
         if (got_t[0] - first_push !== 2) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=2", got_t[0] - first_push);
         end
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL basic_byte[%0d] got=%02h required=%02h", i, got[i], exp_q[i]);
         end
      end
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (got_t[i] - got_t[i-1] !== 34) begin
            failures++;
            $display("FAIL basic_spacing[%0d] got=%0d required=34", i, got_t[i] - got_t[i-1]);
         end
      end
      wait_idle();
      checks++;
      if (frame_count !== 16'd1) begin
         failures++;
         $display("FAIL basic_frame_count got=%0d required=1", frame_count);
      end
   endtask

   task automatic test_fill();
      got.delete(); got_t.delete();
      for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i), 1'b0);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL fill_in_ready got=%b required=0", in_ready);
      end
      for (int i = 16; i < 20; i++) push_byte(8'h30 + 8'(i), i == 19);
      wait_bytes(22);
      checks++;
      if (got[0] !== 8'hFF || got[21] !== 8'h00) begin
         failures++;
         $display("FAIL fill_frame got=%02h..%02h required=FF..00", got[0], got[21]);
      end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (got[i+1] !== 8'h30 + 8'(i)) begin
            failures++;
            $display("FAIL fill_byte[%0d] got=%02h required=%02h", i, got[i+1], 8'h30 + 8'(i));
         end
      end
      checks++;
      if (err_overflow !== 1'b0) begin
         failures++;
         $display("FAIL fill_no_overflow got=%b required=0", err_overflow);
      end
      wait_idle();
      checks++;
      if (frame_count !== 16'd2) begin
         failures++;
         $display("FAIL fill_frame_count got=%0d required=2", frame_count);
      end
   endtask

   task automatic test_overflow();
      got.delete(); got_t.delete();
      for (int i = 0; i < 22; i++) push_byte(8'h41 + 8'(i), i == 21);
      push_byte(8'h7A, 1'b1);
      wait_bytes(22);
      checks++;
      if (err_overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_flag_set got=%b required=1", err_overflow);
      end
      wait_bytes(25);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (got[i+1] !== 8'h41 + 8'(i)) begin
            failures++;
            $display("FAIL ovf_byte[%0d] got=%02h required=%02h", i, got[i+1], 8'h41 + 8'(i));
         end
      end
      checks++;
      if (got[0] !== 8'hFF || got[21] !== 8'h00 || got[22] !== 8'hFF ||
          got[23] !== 8'h7A || got[24] !== 8'h00) begin
         failures++;
         $display("FAIL ovf_frames got=%02h %02h %02h %02h %02h required=FF 00 FF 7A 00",
                  got[0], got[21], got[22], got[23], got[24]);
      end
      checks++;
      if (err_overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_flag_cleared got=%b required=0", err_overflow);
      end
      wait_idle();
      checks++;
      if (frame_count !== 16'd4 || got.size() !== 25) begin
         failures++;
         $display("FAIL ovf_count fc=%0d bytes=%0d required fc=4 bytes=25", frame_count, got.size());
      end
   endtask

   task automatic test_drop();
      logic [7:0] exp_q [$];
      exp_q = '{8'hFF, 8'h61, 8'h62, 8'h00, 8'hFF, 8'h63, 8'h00};
      got.delete(); got_t.delete();
      push_byte(8'h61, 1'b0);
      push_byte(8'h00, 1'b0);
      push_byte(8'h62, 1'b1);
      wait_bytes(4);
      wait_idle();
      // Reserved byte carrying last must still close the frame.
      push_byte(8'h63, 1'b0);
      push_byte(8'hFF, 1'b1);
      wait_bytes(7);
      wait_idle();
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL drop_byte[%0d] got=%02h required=%02h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (frame_count !== 16'd6 || got.size() !== 7) begin
         failures++;
         $display("FAIL drop_count fc=%0d bytes=%0d required fc=6 bytes=7", frame_count, got.size());
      end
   endtask

`ifdef LH_FRAMER_CHARSET_EN
   task automatic test_charset();
      got.delete(); got_t.delete();
      push_byte(8'h0A, 1'b0);
      checks++;
      if (err_charset !== 1'b1) begin
         failures++;
         $display("FAIL charset_flag got=%b required=1", err_charset);
      end
      push_byte(8'h51, 1'b1);
      wait_bytes(3);
      wait_idle();
      checks++;
      if (got.size() !== 3 || got[0] !== 8'hFF || got[1] !== 8'h51 || got[2] !== 8'h00) begin
         failures++;
         $display("FAIL charset_frame size=%0d got=%02h %02h %02h required=FF 51 00",
                  got.size(), got[0], got[1], got[2]);
      end
   endtask
`endif

   task automatic test_reset_midframe();
      got.delete(); got_t.delete();
      for (int i = 0; i < 5; i++) push_byte(8'h76 + 8'(i), i == 4);
      wait_bytes(3);
      checks++;
      if (got[1] !== 8'h76 || got[2] !== 8'h77) begin
         failures++;
         $display("FAIL midrst_pre got=%02h %02h required=76 77", got[1], got[2]);
      end
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (message_byte !== 8'hFF || message_valid !== 1'b0 || busy !== 1'b0 ||
          err_overflow !== 1'b0 || frame_count !== 16'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_async byte=%02h valid=%b busy=%b ovf=%b fc=%0d rdy=%b required FF/0/0/0/0/1",
                  message_byte, message_valid, busy, err_overflow, frame_count, in_ready);
      end
      @(negedge clk);
      got.delete(); got_t.delete();
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      checks++;
      if (got.size() !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_after bytes=%0d busy=%b required bytes=0 busy=0", got.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_overflow();
      test_drop();
`ifdef LH_FRAMER_CHARSET_EN
      test_charset();
`endif
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
